mdu_seq_ctrl: RTL

Sequential multiply/divide unit controller for the MIPS pipeline. It executes MULT/MULTU/DIV/DIVU by iterating a single shared add/subtract datapath one bit per cycle, owns the HI/LO registers and services MTHI/MTLO writes. It sits beside the EX stage. The pipeline stalls on `busy` and can cancel an in-flight operation with `abort` on a flush.

---
 rtl/mdu_if.sv | 27 ++
 rtl/mdu_seq_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// Handshake and HI/LO bus between the EX stage and the multiply/divide controller.
interface mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, abort, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// Bit-serial MULT/MULTU/DIV/DIVU controller owning HI/LO; one shared adder step per cycle.
// Optional MDU_MUL_EARLY_TERM_EN: multiplies stop once the remaining multiplier is zero.
module mdu_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input logic  clk,
    input logic  rst,
    mdu_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q;
    logic               neg_res_q, neg_rem_q, div0_q;
    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [WIDTH-1:0]   opb_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic               busy;

    logic               is_div, calc_last;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     rem_shift;
    logic [2*WIDTH-1:0] add_a, add_b, add_res;
    logic               add_sub;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, dvd_raw;

    assign is_div = op_q[1];

`ifdef MDU_MUL_EARLY_TERM_EN
    assign calc_last = (cnt_q == CW'(WIDTH - 1)) || (!is_div && (opb_q[WIDTH-1:1] == '0));
`else
    assign calc_last = (cnt_q == CW'(WIDTH - 1));
`endif

    // Operand conditioning at launch: signed ops iterate on magnitudes.
    always_comb begin
        a_neg = ~bus.op[0] & bus.a[WIDTH-1];
        b_neg = ~bus.op[0] & bus.b[WIDTH-1];
        a_abs = a_neg ? -bus.a : bus.a;
        b_abs = b_neg ? -bus.b : bus.b;
    end

    // Shared adder: accumulate for multiply, trial-subtract for divide.
    always_comb begin
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        if (is_div) begin
            add_a   = {{(WIDTH - 1){1'b0}}, rem_shift};
            add_b   = {{WIDTH{1'b0}}, opb_q};
            add_sub = 1'b1;
        end else begin
            add_a   = acc_q;
            add_b   = mcand_q;
            add_sub = 1'b0;
        end
        add_res = add_a + (add_b ^ {(2 * WIDTH){add_sub}}) + {{(2 * WIDTH - 1){1'b0}}, add_sub};
    end

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        // mcand_q still holds |a| during a divide; re-signing it recovers the raw dividend.
        dvd_raw  = neg_rem_q ? -mcand_q[WIDTH-1:0] : mcand_q[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StCalc;
            StCalc: begin
                if (bus.abort) state_d = StIdle;
                else if (calc_last) state_d = StFix;
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == StFix) && !bus.abort;
            case (state_q)
                StIdle: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start) begin
                        op_q      <= bus.op;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        div0_q    <= (bus.b == '0);
                        mcand_q   <= {{WIDTH{1'b0}}, a_abs};
                        acc_q     <= bus.op[1] ? {{WIDTH{1'b0}}, a_abs} : '0;
                        opb_q     <= b_abs;
                        cnt_q     <= '0;
                    end
                end
                StCalc: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (is_div) begin
                        if (add_res[2*WIDTH-1]) begin
                            acc_q <= {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        end else begin
                            acc_q <= {add_res[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        if (opb_q[0]) acc_q <= add_res;
                        mcand_q <= mcand_q << 1;
                        opb_q   <= opb_q >> 1;
                    end
                end
                StFix: begin
                    if (!bus.abort) begin
                        if (!is_div) begin
                            {hi_q, lo_q} <= prod_fix;
                        end else if (div0_q) begin
                            hi_q <= dvd_raw;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
